auto_turn_seq: RTL and testbench



---
 rtl/auto_turn_pkg.sv | 19 +
 rtl/ms_down_timer.sv | 34 +++
 rtl/auto_turn_seq.sv | 125 ++++++++++++
 tb/tb_auto_turn_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/auto_turn_pkg.sv
// Shared types and constants for the timed-turn sequencer.
package auto_turn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } turn_state_e;

  localparam int MODE_DIR = 0;
  localparam int MODE_180 = 1;

  localparam logic [1:0] LEFT90   = 2'b00;
  localparam logic [1:0] RIGHT90  = 2'b01;
  localparam logic [1:0] LEFT180  = 2'b10;
  localparam logic [1:0] RIGHT180 = 2'b11;

endpackage

// File: rtl/ms_down_timer.sv
// Loadable millisecond down-counter; holds at zero and flags it combinationally.
module ms_down_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk_ms,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/auto_turn_seq.sv
// Timed-turn sequencer: drives one turn output for a mode-selected time, settles,
// then signals done over a four-phase req/done handshake.
module auto_turn_seq
  import auto_turn_pkg::*;
#(
  parameter int CNT_W     = 12,
  parameter int T90_MS    = 750,
  parameter int T180_MS   = 1500,
  parameter int SETTLE_MS = 250
) (
  input  logic       clk_ms,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] mode,
  output logic       turn_left,
  output logic       turn_right,
  output logic       busy,
  output logic       done
);

  localparam longint MAX_DUR = longint'(1) << CNT_W;

  generate
    if (T90_MS < 1 || longint'(T90_MS) > MAX_DUR) begin : g_bad_t90
      $error("auto_turn_seq: T90_MS out of range for CNT_W");
    end
    if (T180_MS < 1 || longint'(T180_MS) > MAX_DUR) begin : g_bad_t180
      $error("auto_turn_seq: T180_MS out of range for CNT_W");
    end
    if (SETTLE_MS < 1 || longint'(SETTLE_MS) > MAX_DUR) begin : g_bad_settle
      $error("auto_turn_seq: SETTLE_MS out of range for CNT_W");
    end
  endgenerate

  // Timer counts down to zero, so each phase loads its duration minus one.
  localparam logic [CNT_W-1:0] LD_T90    = CNT_W'(T90_MS - 1);
  localparam logic [CNT_W-1:0] LD_T180   = CNT_W'(T180_MS - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_MS - 1);

  turn_state_e      state_q, state_d;
  logic             dir_q, dir_d;
  logic             turn_left_q, turn_right_q, busy_q, done_q;
  logic             t_load, t_en, t_zero;
  logic [CNT_W-1:0] t_val;

  ms_down_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_ms   (clk_ms),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    t_load  = 1'b0;
    t_en    = 1'b0;
    t_val   = LD_T90;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = TURN;
          dir_d   = mode[MODE_DIR];
          t_load  = 1'b1;
          t_val   = mode[MODE_180] ? LD_T180 : LD_T90;
        end
      end
      TURN: begin
        if (!req) begin
          state_d = IDLE;
        end else if (t_zero) begin
          state_d = SETTLE;
          t_load  = 1'b1;
          t_val   = LD_SETTLE;
        end else begin
          t_en = 1'b1;
        end
      end
      SETTLE: begin
        if (!req) begin
          state_d = IDLE;
        end else if (t_zero) begin
          state_d = DONE;
        end else begin
          t_en = 1'b1;
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      turn_left_q  <= 1'b0;
      turn_right_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      turn_left_q  <= (state_d == TURN) && !dir_d;
      turn_right_q <= (state_d == TURN) && dir_d;
      busy_q       <= (state_d == TURN) || (state_d == SETTLE);
      done_q       <= (state_d == DONE);
    end
  end

  assign turn_left  = turn_left_q;
  assign turn_right = turn_right_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_auto_turn_seq.sv
// Directed and randomized checks of auto_turn_seq against an elapsed-time reference model.
module tb_auto_turn_seq;
  import auto_turn_pkg::*;

  localparam int T90  = 5;
  localparam int T180 = 10;
  localparam int SET  = 3;

  logic       clk_ms = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] mode;
  logic       turn_left, turn_right, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: elapsed ticks since acceptance decide the phase.
  bit m_active, m_done, m_dir;
  int m_k, m_dur;

  auto_turn_seq #(
    .CNT_W     (12),
    .T90_MS    (T90),
    .T180_MS   (T180),
    .SETTLE_MS (SET)
  ) dut (
    .clk_ms     (clk_ms),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .turn_left  (turn_left),
    .turn_right (turn_right),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_ms = ~clk_ms;

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_dir    = 1'b0;
    m_k      = 0;
    m_dur    = 0;
  endtask

  task automatic model_edge(input logic r, input logic [1:0] md);
    if (!rst_n) begin
      model_reset();
    end else if (m_active) begin
      if (!r) begin
        m_active = 1'b0;
      end else begin
        m_k = m_k + 1;
        if (m_k == m_dur + SET) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (m_done) begin
      if (!r) m_done = 1'b0;
    end else if (r) begin
      m_active = 1'b1;
      m_k      = 0;
      m_dir    = md[0];
      m_dur    = md[1] ? T180 : T90;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic turning;
    turning = m_active && (m_k < m_dur);
    chk({tag, ".turn_left"},  turn_left,  turning && !m_dir);
    chk({tag, ".turn_right"}, turn_right, turning && m_dir);
    chk({tag, ".busy"},       busy,       m_active);
    chk({tag, ".done"},       done,       m_done);
  endtask

  task automatic step(input string tag, input logic r, input logic [1:0] md);
    req  = r;
    mode = md;
    @(posedge clk_ms);
    model_edge(r, md);
    #1;
    check_all(tag);
  endtask

  task automatic hold(input string tag, input int n, input logic r, input logic [1:0] md);
    for (int i = 0; i < n; i++) step(tag, r, md);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    mode  = LEFT90;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    hold("idle", 20, 1'b0, LEFT90);

    step("l90_acc", 1'b1, LEFT90);
    hold("l90_run", 9, 1'b1, LEFT90);
    step("l90_drop", 1'b0, LEFT90);
    step("l90_idle", 1'b0, LEFT90);

    step("r180_acc", 1'b1, RIGHT180);
    hold("r180_run", 14, 1'b1, LEFT90);
    step("r180_drop", 1'b0, LEFT90);
    step("r180_idle", 1'b0, LEFT90);

    step("abt_turn_acc", 1'b1, LEFT90);
    hold("abt_turn_run", 2, 1'b1, LEFT90);
    step("abt_turn", 1'b0, LEFT90);
    step("abt_turn_idle", 1'b0, LEFT90);
    step("rereq1_acc", 1'b1, RIGHT90);
    hold("rereq1_run", 8, 1'b1, RIGHT90);
    step("rereq1_drop", 1'b0, RIGHT90);

    step("abt_set_acc", 1'b1, RIGHT90);
    hold("abt_set_run", 5, 1'b1, RIGHT90);
    step("abt_set", 1'b0, RIGHT90);
    step("abt_set_idle", 1'b0, RIGHT90);
    step("rereq2_acc", 1'b1, LEFT180);
    hold("rereq2_run", 13, 1'b1, LEFT180);
    step("rereq2_drop", 1'b0, LEFT180);

    step("rst_acc", 1'b1, LEFT90);
    hold("rst_run", 2, 1'b1, LEFT90);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    hold("rst_held", 2, 1'b1, LEFT90);
    req   = 1'b0;
    rst_n = 1'b1;
    step("rst_rel_idle", 1'b0, LEFT90);
    step("post_rst_acc", 1'b1, LEFT90);
    hold("post_rst_run", 9, 1'b1, LEFT90);

    step("b2b_gap", 1'b0, LEFT90);
    step("b2b_acc", 1'b1, RIGHT90);
    hold("b2b_run", 9, 1'b1, RIGHT90);
    step("b2b_drop", 1'b0, RIGHT90);

    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [1:0] md;
      r  = ($urandom_range(0, 9) != 0) ? (m_active || m_done || ($urandom_range(0, 1) == 1)) : 1'b0;
      md = 2'($urandom_range(0, 3));
      step("rand", r, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
